// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter with read sequencing
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              PReq,
  input  logic              PWrite,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic [DATA_W-1:0] PWData,
  output logic              PGnt,
  output logic              PRValid,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              DGnt,
  output logic              DRValid,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemReadEn,
  output logic              MemWriteEn,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int LCW = $clog2(RD_LAT + 1);
  localparam logic [WCW-1:0] WaitMax = WCW'(MAX_WAIT);
  localparam logic [LCW-1:0] LatInit = LCW'(RD_LAT);
  localparam logic [LCW-1:0] LatLast = LCW'(1);

  typedef enum logic [1:0] {IDLE, RDWAIT, RDDONE} StateT;

  StateT             state;
  StateT             stateNext;
  logic [WCW-1:0]    waitCnt;
  logic [LCW-1:0]    latCnt;
  logic              ownerD;
  logic [DATA_W-1:0] rDataQ;
  logic              dWin;

  // D wins only when P is absent or D has been starved long enough
  assign dWin = DReq && (!PReq || (waitCnt == WaitMax));

  // Arbitration, memory command drive and next state
  always_comb begin
    stateNext  = state;
    PGnt       = 1'b0;
    DGnt       = 1'b0;
    MemAddr    = '0;
    MemWData   = '0;
    MemReadEn  = 1'b0;
    MemWriteEn = 1'b0;
    case (state)
      IDLE: begin
        if (dWin) begin
          DGnt       = 1'b1;
          MemAddr    = DAddr;
          MemWData   = DWData;
          MemWriteEn = DWrite;
          MemReadEn  = !DWrite;
          if (!DWrite) stateNext = RDWAIT;
        end else if (PReq) begin
          PGnt       = 1'b1;
          MemAddr    = PAddr;
          MemWData   = PWData;
          MemWriteEn = PWrite;
          MemReadEn  = !PWrite;
          if (!PWrite) stateNext = RDWAIT;
        end
      end
      RDWAIT: begin
        if (latCnt == LatLast) stateNext = RDDONE;
      end
      RDDONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= stateNext;
  end

  // Read latency counter: loaded on a read grant, counts down while waiting
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)               latCnt <= '0;
    else if (MemReadEn)        latCnt <= LatInit;
    else if (state == RDWAIT)  latCnt <= latCnt - LatLast;
  end

  // Remember which requester owns the outstanding read
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)        ownerD <= 1'b0;
    else if (MemReadEn) ownerD <= DGnt;
  end

  // Capture read data on the last latency cycle; held until the next read
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)                                   rDataQ <= '0;
    else if ((state == RDWAIT) && (latCnt == LatLast)) rDataQ <= MemRData;
  end

  // Starvation counter for D, saturating, cleared on grant or withdraw
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)                waitCnt <= '0;
    else if (!DReq || DGnt)     waitCnt <= '0;
    else if (waitCnt != WaitMax) waitCnt <= waitCnt + WCW'(1);
  end

  assign PRValid = (state == RDDONE) && !ownerD;
  assign DRValid = (state == RDDONE) && ownerD;
  assign RData   = rDataQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        Clock;
  logic        nReset;
  logic        nReset3;
  logic        PReq, PWrite, DReq, DWrite;
  logic [15:0] PAddr, DAddr;
  logic [31:0] PWData, DWData;

  logic        PGnt, PRValid, DGnt, DRValid, MemReadEn, MemWriteEn;
  logic [31:0] RData, MemWData, MemRData;
  logic [15:0] MemAddr;

  logic        PGnt3, PRValid3, DGnt3, DRValid3, MemReadEn3, MemWriteEn3;
  logic [31:0] RData3, MemWData3, MemRData3;
  logic [15:0] MemAddr3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic        isD;
    logic [31:0] data;
  } SbT;
  SbT sb[$];
  SbT sb3[$];
  SbT e1, e3;

  typedef struct {
    logic        pReq, pWrite;
    logic [15:0] pAddr;
    logic [31:0] pWData;
    logic        dReq, dWrite;
    logic [15:0] dAddr;
    logic [31:0] dWData;
    logic        ePGnt, eDGnt, eRe, eWe;
    logic [15:0] eAddr;
    logic [31:0] eWData;
    logic [31:0] eRData;
  } VecT;
  localparam int NV = 10;
  VecT vecs[NV];

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .MAX_WAIT(8)) dut (
    .Clock(Clock), .nReset(nReset),
    .PReq(PReq), .PWrite(PWrite), .PAddr(PAddr), .PWData(PWData),
    .PGnt(PGnt), .PRValid(PRValid),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
    .DGnt(DGnt), .DRValid(DRValid),
    .RData(RData), .MemAddr(MemAddr), .MemReadEn(MemReadEn),
    .MemWriteEn(MemWriteEn), .MemWData(MemWData), .MemRData(MemRData)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3), .MAX_WAIT(8)) dut3 (
    .Clock(Clock), .nReset(nReset3),
    .PReq(PReq), .PWrite(PWrite), .PAddr(PAddr), .PWData(PWData),
    .PGnt(PGnt3), .PRValid(PRValid3),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
    .DGnt(DGnt3), .DRValid(DRValid3),
    .RData(RData3), .MemAddr(MemAddr3), .MemReadEn(MemReadEn3),
    .MemWriteEn(MemWriteEn3), .MemWData(MemWData3), .MemRData(MemRData3)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Memory model, RD_LAT=1: data valid only in the cycle after the strobe
  logic [31:0] mem [256];
  logic [31:0] rdQ;
  logic        rvQ;
  always @(posedge Clock) begin
    if (MemWriteEn) mem[MemAddr[9:2]] <= MemWData;
    rvQ <= MemReadEn;
    rdQ <= mem[MemAddr[9:2]];
  end
  assign MemRData = rvQ ? rdQ : 32'hBAD0BAD0;

  // Memory model, RD_LAT=3: data valid only three cycles after the strobe
  logic [31:0] mem3 [256];
  logic [31:0] d3 [3];
  logic        v3 [3];
  always @(posedge Clock) begin
    if (MemWriteEn3) mem3[MemAddr3[9:2]] <= MemWData3;
    v3[0] <= MemReadEn3;
    d3[0] <= mem3[MemAddr3[9:2]];
    v3[1] <= v3[0];
    d3[1] <= d3[0];
    v3[2] <= v3[1];
    d3[2] <= d3[1];
  end
  assign MemRData3 = v3[2] ? d3[2] : 32'hBAD0BAD0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pr, input logic pw, input logic [15:0] pa, input logic [31:0] pd,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [31:0] dd);
    PReq = pr; PWrite = pw; PAddr = pa; PWData = pd;
    DReq = dr; DWrite = dw; DAddr = da; DWData = dd;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0);
  endtask

  // Scoreboard for the RD_LAT=1 instance
  always @(negedge Clock) begin
    #2;
    if (nReset) begin
      chk1("gnt_exclusive", PGnt & DGnt, 1'b0);
      if (PRValid || DRValid) begin
        if (sb.size() == 0) chk1("unexpected_rvalid", 1'b1, 1'b0);
        else begin
          e1 = sb.pop_front();
          chk1("rvalid_owner", DRValid, e1.isD);
          chk1("rvalid_single", PRValid & DRValid, 1'b0);
          chk32("rdata", RData, e1.data);
        end
      end
    end
  end

  // Scoreboard for the RD_LAT=3 instance
  always @(negedge Clock) begin
    #2;
    if (nReset3) begin
      chk1("gnt_exclusive3", PGnt3 & DGnt3, 1'b0);
      if (PRValid3 || DRValid3) begin
        if (sb3.size() == 0) chk1("unexpected_rvalid3", 1'b1, 1'b0);
        else begin
          e3 = sb3.pop_front();
          chk1("rvalid_owner3", DRValid3, e3.isD);
          chk32("rdata3", RData3, e3.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, denied;
    logic got;

    vecs[0] = '{0,0,16'h0000,32'h0,        0,0,16'h0000,32'h0,        0,0,0,0,16'h0000,32'h0,        32'h0};
    vecs[1] = '{1,1,16'h0010,32'hDEADBEEF, 0,0,16'h0000,32'h0,        1,0,0,1,16'h0010,32'hDEADBEEF, 32'h0};
    vecs[2] = '{0,0,16'h0000,32'h0,        1,1,16'h0024,32'h22222222, 0,1,0,1,16'h0024,32'h22222222, 32'h0};
    vecs[3] = '{1,0,16'h0010,32'h0,        0,0,16'h0000,32'h0,        1,0,1,0,16'h0010,32'h0,        32'hDEADBEEF};
    vecs[4] = '{1,1,16'h0030,32'h33333333, 1,1,16'h0034,32'h44444444, 1,0,0,1,16'h0030,32'h33333333, 32'h0};
    vecs[5] = '{1,1,16'h0038,32'h55555555, 1,0,16'h0020,32'h0,        1,0,0,1,16'h0038,32'h55555555, 32'h0};
    vecs[6] = '{0,0,16'h0000,32'h0,        1,0,16'h0024,32'h0,        0,1,1,0,16'h0024,32'h0,        32'h22222222};
    vecs[7] = '{1,1,16'h0020,32'h11111111, 0,0,16'h0000,32'h0,        1,0,0,1,16'h0020,32'h11111111, 32'h0};
    vecs[8] = '{1,0,16'h0020,32'h0,        0,0,16'h0000,32'h0,        1,0,1,0,16'h0020,32'h0,        32'h11111111};
    vecs[9] = '{0,0,16'h0000,32'h0,        1,0,16'h0030,32'h0,        0,1,1,0,16'h0030,32'h0,        32'h33333333};

    idle();
    nReset = 1'b0;
    nReset3 = 1'b0;
    repeat (2) @(negedge Clock);
    #2;
    chk1("rst_pgnt", PGnt, 1'b0);
    chk1("rst_dgnt", DGnt, 1'b0);
    chk1("rst_prvalid", PRValid, 1'b0);
    chk1("rst_drvalid", DRValid, 1'b0);
    chk1("rst_memre", MemReadEn, 1'b0);
    chk1("rst_memwe", MemWriteEn, 1'b0);
    chk32("rst_memaddr", {16'h0, MemAddr}, 32'h0);
    chk32("rst_rdata", RData, 32'h0);
    nReset = 1'b1;

    // Single-cycle arbitration vectors, each from IDLE with WaitCnt = 0
    for (int i = 0; i < NV; i++) begin
      @(negedge Clock);
      drive(vecs[i].pReq, vecs[i].pWrite, vecs[i].pAddr, vecs[i].pWData,
            vecs[i].dReq, vecs[i].dWrite, vecs[i].dAddr, vecs[i].dWData);
      #2;
      chk1("vec_pgnt", PGnt, vecs[i].ePGnt);
      chk1("vec_dgnt", DGnt, vecs[i].eDGnt);
      chk1("vec_memre", MemReadEn, vecs[i].eRe);
      chk1("vec_memwe", MemWriteEn, vecs[i].eWe);
      chk32("vec_memaddr", {16'h0, MemAddr}, {16'h0, vecs[i].eAddr});
      chk32("vec_memwdata", MemWData, vecs[i].eWData);
      if (vecs[i].eRe) sb.push_back('{vecs[i].eDGnt, vecs[i].eRData});
      @(negedge Clock);
      idle();
      repeat (3) @(negedge Clock);
    end

    // P read latency and earliest regrant, request held throughout
    @(negedge Clock);
    drive(1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0);
    #2;
    chk1("t1_pgnt_n", PGnt, 1'b1);
    n = cyc;
    sb.push_back('{1'b0, 32'hDEADBEEF});
    @(negedge Clock); #2;
    chk1("t1_pgnt_n1", PGnt, 1'b0);
    chk1("t1_prvalid_n1", PRValid, 1'b0);
    @(negedge Clock); #2;
    chk1("t1_pgnt_n2", PGnt, 1'b0);
    chk1("t1_prvalid_n2", PRValid, 1'b1);
    @(negedge Clock); #2;
    chk1("t1_pgnt_n3", PGnt, 1'b1);
    chk32("t1_regrant_gap", n + 3, cyc);
    sb.push_back('{1'b0, 32'hDEADBEEF});
    @(negedge Clock);
    idle();
    repeat (4) @(negedge Clock);

    // Simultaneous writes: P first, D next cycle, both land in memory
    drive(1, 1, 16'h0060, 32'hA5A5A5A5, 1, 1, 16'h0064, 32'h5A5A5A5A);
    #2;
    chk1("t2_pgnt", PGnt, 1'b1);
    chk1("t2_dgnt_first", DGnt, 1'b0);
    @(negedge Clock);
    drive(0, 0, 16'h0, 32'h0, 1, 1, 16'h0064, 32'h5A5A5A5A);
    #2;
    chk1("t2_dgnt", DGnt, 1'b1);
    chk32("t2_dmemaddr", {16'h0, MemAddr}, 32'h0064);
    @(negedge Clock);
    idle();
    #2;
    chk32("t2_mem_p", mem[8'h18], 32'hA5A5A5A5);
    chk32("t2_mem_d", mem[8'h19], 32'h5A5A5A5A);
    repeat (2) @(negedge Clock);

    // Starvation: D forced after exactly 8 denied cycles, twice in a row
    drive(1, 1, 16'h0050, 32'h1, 1, 1, 16'h0054, 32'h2);
    for (int k = 0; k < 2; k++) begin
      denied = 0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        #2;
        if (DGnt) got = 1'b1;
        else denied++;
        @(negedge Clock);
      end
      chk1("t3_dgnt_seen", got, 1'b1);
      chk32("t3_denied", denied, 32'd8);
    end
    idle();
    repeat (3) @(negedge Clock);

    // Withdraw: D drops before grant, then needs a full 8 denied cycles again
    drive(1, 1, 16'h0070, 32'h7, 1, 1, 16'h0074, 32'h8);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk1("t6_no_dgnt", DGnt, 1'b0);
      chk1("t6_pgnt", PGnt, 1'b1);
      @(negedge Clock);
    end
    drive(1, 1, 16'h0070, 32'h7, 0, 0, 16'h0, 32'h0);
    #2;
    chk1("t6_pgnt_after_withdraw", PGnt, 1'b1);
    @(negedge Clock);
    drive(1, 1, 16'h0070, 32'h7, 1, 1, 16'h0074, 32'h8);
    denied = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #2;
      if (DGnt) got = 1'b1;
      else denied++;
      @(negedge Clock);
    end
    chk1("t6_dgnt_seen", got, 1'b1);
    chk32("t6_denied", denied, 32'd8);
    idle();
    repeat (3) @(negedge Clock);

    // RD_LAT=3: D read, P waiting; no grants until the read completes
    nReset3 = 1'b1;
    @(negedge Clock);
    drive(1, 1, 16'h0040, 32'hCAFEF00D, 0, 0, 16'h0, 32'h0);
    #2;
    chk1("t4_pgnt_wr", PGnt3, 1'b1);
    @(negedge Clock);
    drive(0, 0, 16'h0, 32'h0, 1, 0, 16'h0040, 32'h0);
    #2;
    chk1("t4_dgnt", DGnt3, 1'b1);
    chk1("t4_memre", MemReadEn3, 1'b1);
    sb3.push_back('{1'b1, 32'hCAFEF00D});
    sb.push_back('{1'b1, 32'hCAFEF00D});
    @(negedge Clock);
    drive(1, 1, 16'h0044, 32'h66666666, 0, 0, 16'h0, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      #2;
      if (k < 5) begin
        chk1("t4_no_pgnt", PGnt3, 1'b0);
        chk1("t4_no_dgnt", DGnt3, 1'b0);
        chk1("t4_drvalid", DRValid3, k == 4);
      end else begin
        chk1("t4_pgnt_follow", PGnt3, 1'b1);
      end
      @(negedge Clock);
    end
    idle();
    repeat (3) @(negedge Clock);
    nReset3 = 1'b0;

    // Reset during RDWAIT aborts the read; a fresh read then works
    @(negedge Clock);
    drive(1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0);
    #2;
    chk1("t5_pgnt", PGnt, 1'b1);
    @(negedge Clock);
    idle();
    #2;
    nReset = 1'b0;
    sb.delete();
    #1;
    chk1("t5_rst_prvalid", PRValid, 1'b0);
    chk1("t5_rst_memre", MemReadEn, 1'b0);
    chk1("t5_rst_pgnt", PGnt, 1'b0);
    chk32("t5_rst_rdata", RData, 32'h0);
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    repeat (5) @(negedge Clock);
    drive(1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0);
    #2;
    chk1("t5_fresh_pgnt", PGnt, 1'b1);
    sb.push_back('{1'b0, 32'hDEADBEEF});
    @(negedge Clock);
    idle();
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #2;
      if (PRValid) got = 1'b1;
      @(negedge Clock);
    end
    chk1("t5_fresh_prvalid", got, 1'b1);

    repeat (3) @(negedge Clock);
    chk32("sb_drained", sb.size(), 32'd0);
    chk32("sb3_drained", sb3.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
